// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO page (cycle counter, scratch, TX FIFO).
// Optional store-fault tracking is enabled by defining DMEM_FAULT_EN.
module dmem_responder #(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFFFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        fault
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0]   RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [5:0] OFF_CYCLE   = 6'h00;
  localparam logic [5:0] OFF_SCRATCH = 6'h01;
  localparam logic [5:0] OFF_TXDATA  = 6'h02;
  localparam logic [5:0] OFF_TXSTAT  = 6'h03;
  localparam logic [5:0] OFF_DROPS   = 6'h04;
  localparam logic [5:0] OFF_FADDR   = 6'h05;

  logic          ram_hit_s, mmio_hit_s, bad_store_s, store_ok_s;
  logic [5:0]    off_s;
  logic [AW-1:0] ram_idx_s;
  logic          push_s, pop_s, accept_s, drop_s, full_s, empty_s;
  logic [31:0]   faddr_s;

  logic [31:0]   ram_r [RAM_WORDS];
  logic [31:0]   fifo_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   cycle_r, scratch_r;
  logic [15:0]   drops_r;

  assign ram_hit_s  = (a < RAM_BYTES);
  assign mmio_hit_s = (a[31:8] == MMIO_BASE[31:8]);
  assign off_s      = a[7:2];
  assign ram_idx_s  = a[AW+1:2];

`ifdef DMEM_FAULT_EN
  // A store is bad if misaligned, unmapped, or aimed at a read-only register.
  assign bad_store_s = we & ((a[1:0] != 2'b00) | !(ram_hit_s | mmio_hit_s) |
                             (mmio_hit_s & ((off_s == OFF_CYCLE) | (off_s == OFF_TXSTAT) |
                                            (off_s == OFF_DROPS) | (off_s == OFF_FADDR))));
`else
  assign bad_store_s = 1'b0;
`endif

  assign store_ok_s = we & !reset & !bad_store_s;
  assign push_s     = store_ok_s & mmio_hit_s & (off_s == OFF_TXDATA);
  assign full_s     = (count_r == CNT_FULL);
  assign empty_s    = (count_r == {CW{1'b0}});
  assign pop_s      = out_valid & out_ready;
  assign accept_s   = push_s & (!full_s | pop_s);
  assign drop_s     = push_s & !accept_s;
  assign out_valid  = !empty_s;
  assign out_data   = empty_s ? 32'h0 : fifo_r[rd_ptr_r];

  // RAM array; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (store_ok_s && ram_hit_s) begin
      ram_r[ram_idx_s] <= wd;
    end
  end

  // FIFO storage; stale entries are harmless because pointers reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      fifo_r[wr_ptr_r] <= wd;
    end
  end

  // MMIO registers and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_r   <= 32'h0;
      scratch_r <= 32'h0;
      drops_r   <= 16'h0;
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      count_r   <= {CW{1'b0}};
    end else begin
      cycle_r <= cycle_r + 32'h1;
      if (store_ok_s && mmio_hit_s && (off_s == OFF_SCRATCH)) begin
        scratch_r <= wd;
      end
      if (drop_s && (drops_r != 16'hFFFF)) begin
        drops_r <= drops_r + 16'h1;
      end
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef DMEM_FAULT_EN
  logic        fault_r;
  logic [31:0] faddr_r;

  // Sticky fault flag; only the first offending address is captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_r <= 1'b0;
      faddr_r <= 32'h0;
    end else if (bad_store_s && !fault_r) begin
      fault_r <= 1'b1;
      faddr_r <= a;
    end
  end

  assign fault   = fault_r;
  assign faddr_s = faddr_r;
`else
  assign fault   = 1'b0;
  assign faddr_s = 32'h0;
`endif

  // Combinational load mux.
  always_comb begin
    rd = 32'h0;
    if (ram_hit_s) begin
      rd = ram_r[ram_idx_s];
    end else if (mmio_hit_s) begin
      case (off_s)
        OFF_CYCLE:   rd = cycle_r;
        OFF_SCRATCH: rd = scratch_r;
        OFF_TXSTAT:  rd = {24'h0, 6'(count_r), full_s, empty_s};
        OFF_DROPS:   rd = {16'h0, drops_r};
        OFF_FADDR:   rd = faddr_s;
        default:     rd = 32'h0;
      endcase
    end else begin
      rd = 32'h0;
    end
  end

endmodule
